buffered_write_master: RTL
==========================

BUFFERED_WRITE_MASTER -- requirements
Module: buffered_write_master

Interface
REQ-001 Parameter DATAWIDTH, default 32, SHALL set the width of the data bus and of the FIFO words.
REQ-002 Parameter ADDRESSWIDTH, default 32, SHALL set the width of the address and length fields.
REQ-003 Parameter FIFODEPTH, default 32, SHALL set the number of FIFO words.
REQ-004 Parameter FIFODEPTH_LOG2, default 5, SHALL equal log2(FIFODEPTH).
REQ-005 Port clk SHALL be an input, 1 bit: the clock; all logic is rising-edge.
REQ-006 Port reset_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-007 Port control_fixed_location SHALL be an input, 1 bit: 1 = do not increment the address; sampled on go.
REQ-008 Port control_write_base SHALL be an input, ADDRESSWIDTH bits: word-aligned start address.
REQ-009 Port control_write_length SHALL be an input, ADDRESSWIDTH bits: transfer length in bytes.
REQ-010 Port control_go SHALL be an input, 1 bit: single-cycle start pulse.
REQ-011 Port control_done SHALL be an output, 1 bit: all writes are accepted.
REQ-012 Port user_write_buffer SHALL be an input, 1 bit: push user_buffer_data into the FIFO.
REQ-013 Port user_buffer_data SHALL be an input, DATAWIDTH bits: FIFO write data.
REQ-014 Port user_buffer_full SHALL be an output, 1 bit: FIFO full.
REQ-015 Port user_buffer_used SHALL be an output, FIFODEPTH_LOG2+1 bits: current FIFO word count.
REQ-016 Port master_address SHALL be an output, ADDRESSWIDTH bits: Avalon-MM address.
REQ-017 Port master_write SHALL be an output, 1 bit: Avalon-MM write request.
REQ-018 Port master_byteenable SHALL be an output, DATAWIDTH/8 bits: byte enables.
REQ-019 Port master_writedata SHALL be an output, DATAWIDTH bits: write data.
REQ-020 Port master_waitrequest SHALL be an input, 1 bit: slave stall.

Function
REQ-021 The FIFO SHALL be show-ahead: master_writedata equals the oldest stored word with zero read latency.
REQ-022 A push SHALL occur when user_write_buffer=1 and the FIFO is not full; a push while full SHALL be dropped and the FIFO contents left unchanged.
REQ-023 A push and a pop in the same cycle SHALL leave user_buffer_used unchanged.
REQ-024 user_buffer_full SHALL equal (user_buffer_used == FIFODEPTH).
REQ-025 The internal read/write pointers SHALL wrap modulo FIFODEPTH.
REQ-026 When control_go=1, the block SHALL load address <= control_write_base, length <= control_write_length with bits[1:0] forced to 0, and fixed_d1 <= control_fixed_location.
REQ-027 master_write SHALL equal (length != 0) & (FIFO not empty), and SHALL be driven combinationally.
REQ-028 An accept SHALL be defined as master_write & !master_waitrequest.
REQ-029 On accept, the FIFO SHALL pop one word and length SHALL decrease by 4.
REQ-030 On accept, address SHALL increase by 4 unless fixed_d1=1, in which case it is held.
REQ-031 master_byteenable SHALL be all ones; master_address SHALL equal address.
REQ-032 While master_waitrequest=1, master_address and master_writedata SHALL be held stable.
REQ-033 control_done SHALL equal (length == 0), driven combinationally.
REQ-034 control_go SHALL have priority over an accept in the same cycle: address and length take the go values, and the accepted word is still popped.
REQ-035 A control_go pulse mid-transfer SHALL restart with the new base and length and SHALL keep the FIFO contents.
REQ-036 FIFO words beyond the programmed length SHALL remain in the FIFO for the next transfer.
REQ-037 Address and length arithmetic SHALL be modulo 2^ADDRESSWIDTH, with no overflow detection.

Reset
REQ-038 While reset_n=0, all registers SHALL clear asynchronously: address=0, length=0, fixed_d1=0, FIFO empty.
REQ-039 During reset, outputs SHALL be: master_write=0, control_done=1, user_buffer_full=0, user_buffer_used=0, master_address=0.
REQ-040 Reset asserted mid-transfer SHALL abort the transfer and discard the FIFO contents.

Verification
REQ-041 Basic transfer: push 4 words A..D, then go with base=0x100 and len=16, waitrequest=0 -> writes A..D to 0x100, 0x104, 0x108, 0x10C on consecutive cycles; control_done=1 the cycle after the 4th accept.
REQ-042 Stall: same as REQ-041 with waitrequest=1 for 3 cycles on the 2nd word -> address 0x104 and data B held 3 cycles; total of 4 accepts only.
REQ-043 Empty FIFO: go with len=8 and FIFO empty -> master_write=0 until the first push; then the pushed word is written the cycle after the push.
REQ-044 Full FIFO and fixed location: fill 32 words, then push a 33rd -> dropped, used=32; then go with fixed=1 and len=128 -> 32 writes, all to base.
REQ-045 Mid-operation events: go mid-transfer -> address and length reload and the FIFO is intact; then reset_n low mid-transfer -> master_write=0, used=0, control_done=1 immediately.

Source files
------------

// File: rtl/buffered_write_master_if.sv
// Signal bundle between the buffered write master, its controller/user logic and
// the Avalon-MM slave it writes into.
interface buffered_write_master_if #(
    parameter int DATAWIDTH      = 32,
    parameter int ADDRESSWIDTH   = 32,
    parameter int FIFODEPTH_LOG2 = 5
);
    logic                      control_fixed_location;
    logic [ADDRESSWIDTH-1:0]   control_write_base;
    logic [ADDRESSWIDTH-1:0]   control_write_length;
    logic                      control_go;
    logic                      control_done;

    logic                      user_write_buffer;
    logic [DATAWIDTH-1:0]      user_buffer_data;
    logic                      user_buffer_full;
    logic [FIFODEPTH_LOG2:0]   user_buffer_used;

    logic [ADDRESSWIDTH-1:0]   master_address;
    logic                      master_write;
    logic [DATAWIDTH/8-1:0]    master_byteenable;
    logic [DATAWIDTH-1:0]      master_writedata;
    logic                      master_waitrequest;

    modport master (
        input  control_fixed_location, control_write_base, control_write_length, control_go,
        input  user_write_buffer, user_buffer_data, master_waitrequest,
        output control_done, user_buffer_full, user_buffer_used,
        output master_address, master_write, master_byteenable, master_writedata
    );

    modport slave (
        output control_fixed_location, control_write_base, control_write_length, control_go,
        output user_write_buffer, user_buffer_data, master_waitrequest,
        input  control_done, user_buffer_full, user_buffer_used,
        input  master_address, master_write, master_byteenable, master_writedata
    );
endinterface

// File: rtl/buffered_write_master.sv
// Avalon-MM write master fed by a show-ahead FIFO: streams buffered words to
// consecutive (or one fixed) word address until the programmed byte length is written.
module buffered_write_master #(
    parameter int DATAWIDTH      = 32,
    parameter int ADDRESSWIDTH   = 32,
    parameter int FIFODEPTH      = 32,
    parameter int FIFODEPTH_LOG2 = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    buffered_write_master_if.master  bus
);
    localparam logic [FIFODEPTH_LOG2:0]   DEPTH_CNT = (FIFODEPTH_LOG2+1)'(FIFODEPTH);
    localparam logic [FIFODEPTH_LOG2-1:0] LAST_PTR  = FIFODEPTH_LOG2'(FIFODEPTH - 1);
    localparam logic [ADDRESSWIDTH-1:0]   WORD_BYTES = ADDRESSWIDTH'(4);

    logic [DATAWIDTH-1:0]      fifo_mem [FIFODEPTH];
    logic [FIFODEPTH_LOG2-1:0] wr_ptr;
    logic [FIFODEPTH_LOG2-1:0] rd_ptr;
    logic [FIFODEPTH_LOG2:0]   used;
    logic [ADDRESSWIDTH-1:0]   address;
    logic [ADDRESSWIDTH-1:0]   length;
    logic                      fixed_d1;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic accept;

    assign fifo_full  = (used == DEPTH_CNT);
    assign fifo_empty = (used == '0);
    assign push       = bus.user_write_buffer & ~fifo_full;
    assign accept     = bus.master_write & ~bus.master_waitrequest;

    // FIFO storage carries no reset; emptiness is defined purely by the counters
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.user_buffer_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (accept) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, accept})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    // A go pulse wins over a concurrent accept; the accepted word is still popped above
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address  <= '0;
            length   <= '0;
            fixed_d1 <= 1'b0;
        end else if (bus.control_go) begin
            address  <= bus.control_write_base;
            length   <= bus.control_write_length & ~ADDRESSWIDTH'(3);
            fixed_d1 <= bus.control_fixed_location;
        end else if (accept) begin
            length <= length - WORD_BYTES;
            if (!fixed_d1) begin
                address <= address + WORD_BYTES;
            end
        end
    end

    assign bus.master_write      = (length != '0) & ~fifo_empty;
    assign bus.master_address    = address;
    assign bus.master_byteenable = '1;
    assign bus.master_writedata  = fifo_mem[rd_ptr];
    assign bus.control_done      = (length == '0);
    assign bus.user_buffer_full  = fifo_full;
    assign bus.user_buffer_used  = used;
endmodule
